// File: rtl/wshb_pkg.sv
// Shared Wishbone definitions: cycle/burst type encodings and slave FSM state codes.
package wshb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00
  } bte_e;

  typedef logic [1:0] slv_state_t;

  localparam slv_state_t ST_IDLE = 2'd0;
  localparam slv_state_t ST_WAIT = 2'd1;
  localparam slv_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-feedback bus bundle with master and slave views.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  clk, rst,
    input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_be_ram.sv
// Single-port DEPTH x 32 RAM with byte write enables and an enabled, clearable
// registered read port, shaped to map onto block RAM.
module wshb_be_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic          clr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Output register only moves on an enabled read, so it holds between transfers.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone slave fronting a byte-enabled RAM: optional wait states, range
// decode with error termination, and zero-wait incrementing bursts.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  wshb_if.slave wshb_ifs
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          BURST_OK = (WAIT_STATES == 0);

  logic        clk;
  logic        rst;
  logic        req;
  logic        hit;
  logic        enter_resp;
  logic        take;

  slv_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        burst_q, burst_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [3:0]  ram_we;
  logic        ram_re;
  logic        ram_clr;
  logic [31:0] ram_rdata;
  logic [1:0]  unused_adr;

  assign clk        = wshb_ifs.clk;
  assign rst        = wshb_ifs.rst;
  assign req        = wshb_ifs.cyc & wshb_ifs.stb;
  assign hit        = (wshb_ifs.adr[31:2] < DEPTH_W);
  assign unused_adr = wshb_ifs.adr[1:0];

  // burst_q records whether the beat now being terminated announced a follower;
  // the follower's own adr is the one on the bus during that termination cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (BURST_OK && burst_q && req) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enter_resp) begin
      burst_d = (wshb_ifs.cti == CTI_INCR) && (wshb_ifs.bte == BTE_LINEAR);
    end
  end

  assign take  = enter_resp & ~rst;
  assign ack_d = take & hit;
  assign err_d = take & ~hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ram_we  = {4{take & wshb_ifs.we & hit}} & wshb_ifs.sel;
  assign ram_re  = take & ~wshb_ifs.we & hit;
  assign ram_clr = rst | (take & ~hit);

  wshb_be_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (wshb_ifs.adr[AW+1:2]),
    .wdata_i (wshb_ifs.dat_ms),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .rdata_o (ram_rdata)
  );

  assign wshb_ifs.dat_sm = ram_rdata;
  assign wshb_ifs.ack    = ack_q;
  assign wshb_ifs.err    = err_q;
  assign wshb_ifs.rty    = 1'b0;

endmodule

// File: doc/wshb_ram_slave.md
WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the number of 32-bit memory words; legal values are 2..65536.
REQ-002 Parameter WAIT_STATES, default 0, SHALL set the extra idle cycles inserted before each ack; legal values are 0..15.
REQ-003 Ports SHALL be a single Wishbone slave modport, wshb_if.slave wshb_ifs, with the members listed below.
REQ-004 wshb_ifs.clk  in  1  sole clock; all logic on its rising edge.
REQ-005 wshb_ifs.rst  in  1  reset, synchronous, active-high.
REQ-006 cyc  in  1  bus cycle valid.
REQ-007 stb  in  1  transfer strobe.
REQ-008 we  in  1  1 = write, 0 = read.
REQ-009 sel  in  4  byte-lane enables.
REQ-010 adr  in  32  byte address; bits [1:0] ignored.
REQ-011 dat_ms  in  32  write data.
REQ-012 cti  in  3  cycle type identifier (000 classic, 010 incrementing burst, 111 end of burst).
REQ-013 bte  in  2  burst type extension; only 00 (linear) is supported.
REQ-014 dat_sm  out  32  read data.
REQ-015 ack  out  1  normal termination.
REQ-016 err  out  1  error termination.
REQ-017 rty  out  1  retry; tied to 0.

Function
REQ-018 The slave SHALL use an FSM with states IDLE, WAIT and RESP.
- IDLE -> WAIT: cyc&stb with WAIT_STATES>0; the wait counter is loaded with WAIT_STATES-1.
- IDLE -> RESP: cyc&stb with WAIT_STATES=0.
REQ-019 In WAIT, the wait counter SHALL decrement each cycle; the FSM SHALL move to RESP on the cycle after it reaches 0.
REQ-020 If cyc or stb is 0 in WAIT, the transfer SHALL be aborted: FSM -> IDLE, no ack, no err, no memory write.
REQ-021 The termination signal (ack or err) SHALL be high exactly in RESP cycles; latency from first cyc&stb to termination is 1+WAIT_STATES cycles.
REQ-022 The word index SHALL be adr[31:2], sampled on the clock edge that enters RESP.
- Index < DEPTH: RESP drives ack.
- Otherwise: RESP drives err; memory is not modified and dat_sm is 0.
REQ-023 Writes SHALL update, at the edge entering RESP, only the byte lanes whose sel bit is 1; sel=0000 SHALL produce an ack with no write.
REQ-024 On a read, dat_sm SHALL be registered at the edge entering RESP and hold the full 32-bit word regardless of sel; dat_sm SHALL hold its value outside RESP.
REQ-025 From RESP, in classic mode (cti≠010, or WAIT_STATES>0, or bte≠00), the FSM SHALL return to IDLE, so that stb held high yields one ack every 2+WAIT_STATES cycles.
REQ-026 From RESP, with cti=010, bte=00, WAIT_STATES=0 and cyc&stb high, the FSM SHALL stay in RESP and serve the current adr, giving back-to-back acks.
REQ-027 A transfer with cti=111 SHALL end the burst: after its termination, the FSM goes to IDLE.
REQ-028 If the address changes mid-burst, the presented adr SHALL be honoured; the slave performs no internal address prediction.
REQ-029 Simultaneous ack and err SHALL never occur; rty SHALL always be 0.

Reset
REQ-030 rst SHALL force the FSM to IDLE, the wait counter to 0, ack=0, err=0 and dat_sm=0 on the next edge, including mid-WAIT and mid-burst; a write in progress SHALL NOT commit.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package wshb_pkg SHALL hold the cti and bte enums (CTI_CLASSIC, CTI_INCR, CTI_EOB; BTE_LINEAR) and the slave state typedef; the FSM SHALL use these, not literals.
REQ-033 The memory SHALL be a sub-module wshb_be_ram (DEPTH x 32, four byte-write enables, registered read port) so that it maps to block RAM; the FSM and decode stay in wshb_ram_slave.

Verification
REQ-034 Classic write, then read: write adr=0x10, dat=0xDEADBEEF, sel=F, then read adr=0x10 -> ack 1 cycle after strobe, dat_sm=0xDEADBEEF.
REQ-035 Byte lanes: write 0x11223344 with sel=F, then 0xAABBCCDD with sel=0101, then read -> 0x11BB33DD.
REQ-036 Held-stb stream: cti=0, stb held high for 64 acks writing the addresses 0,4,...,252 -> acks every 2nd cycle, 64 acks; read-back matches.
REQ-037 Burst: WAIT_STATES=0, cti=010 over 4 beats at adr 0x0..0xC, last beat cti=111 -> 4 consecutive ack cycles, then ack=0.
REQ-038 Out-of-range and wait states: WAIT_STATES=3, read adr=4*DEPTH -> err after 4 cycles, ack=0, dat_sm=0; cyc dropped in WAIT -> no response, memory unchanged.
REQ-039 Reset mid-WAIT during a write -> ack=0 and err=0 the next cycle; target word unchanged on read-back.
